// File: rtl/lif_layer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lif_pkg
// Brief    : Q4.4 types, scheduler state encoding and the shared LIF step.
// Revision : 1.0
// ============================================================================
package lif_pkg;

    typedef logic signed [7:0] q4_4_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DRAIN  = 2'd2
    } sched_state_e;

    typedef struct packed {
        q4_4_t p;
        logic  fire;
    } lif_result_t;

    localparam q4_4_t c_lambda       = 8'sb0001_0100;
    localparam q4_4_t c_threshold    = 8'sb0100_0000;
    localparam q4_4_t c_reset_level  = 8'sb0000_0000;
    localparam q4_4_t c_spike_weight = 8'sb0001_0000;

    function automatic lif_result_t lif_step(
        input q4_4_t p,
        input logic  spike,
        input q4_4_t lambda      = c_lambda,
        input q4_4_t threshold   = c_threshold,
        input q4_4_t weight      = c_spike_weight,
        input q4_4_t reset_level = c_reset_level
    );
        logic signed [15:0] mul;
        q4_4_t              leak;
        logic signed [8:0]  sum;
        q4_4_t              sat;
        lif_result_t        res;
        mul  = 16'(p) * 16'(lambda);
        // Keep product bits [11:4]: Q8.8 back to Q4.4 with wrap on the top
        leak = q4_4_t'(mul >>> 4);
        sum  = 9'(leak) + (spike ? 9'(weight) : 9'sd0);
        if (sum > 9'sd127)
            sat = 8'sd127;
        else if (sum < -9'sd128)
            sat = -8'sd128;
        else
            sat = sum[7:0];
        res.fire = (sat >= threshold);
        res.p    = res.fire ? reset_level : sat;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_layer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lif_layer_scheduler_if
// Brief    : Input spike event stream and output spike event stream.
// Revision : 1.0
// ============================================================================
interface lif_layer_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_valid, in_idx, out_ready,
        input  in_ready, out_valid, out_idx
    );

    modport slave (
        input  in_valid, in_idx, out_ready,
        output in_ready, out_valid, out_idx
    );
endinterface
`default_nettype wire

// File: rtl/lif_layer_scheduler_spike_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spike_fifo
// Brief    : Synchronous FIFO with a registered output stage and empty flag.
// Revision : 1.0
// ============================================================================
module spike_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_idx,
    input  wire logic             pop,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_idx,
    output logic                  empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr;
    logic [c_aw:0]    r_rd;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_idx;
    logic             w_load;

    // Refill the output stage whenever it is empty or being consumed
    assign w_load    = (r_wr != r_rd) && (!r_out_valid || pop);
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign empty     = (r_wr == r_rd) && !r_out_valid;

    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr[c_aw-1:0]] <= push_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            if (push)
                r_wr <= r_wr + 1'b1;
            if (w_load) begin
                r_out_idx   <= r_mem[r_rd[c_aw-1:0]];
                r_out_valid <= 1'b1;
                r_rd        <= r_rd + 1'b1;
            end else if (pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/lif_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_layer_scheduler
// Brief    : Time-multiplexed LIF layer: one update datapath swept over all
//            virtual neurons per tick, fired indices streamed out in order.
// Revision : 1.0
// ============================================================================
module lif_layer_scheduler
    import lif_pkg::*;
#(
    parameter int    N_NEURONS    = 16,
    parameter int    IDX_W        = $clog2(N_NEURONS),
    parameter q4_4_t LAMBDA       = c_lambda,
    parameter q4_4_t THRESHOLD    = c_threshold,
    parameter q4_4_t RESET_LEVEL  = c_reset_level,
    parameter q4_4_t SPIKE_WEIGHT = c_spike_weight
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              tick,
    lif_layer_scheduler_if.slave   bus,
    output logic                   busy,
    output logic                   done,
    output logic                   tick_overrun
);
    sched_state_e         r_state;
    logic [IDX_W-1:0]     r_cnt;
    logic [N_NEURONS-1:0] r_pending;
    logic [N_NEURONS-1:0] r_snapshot;
    q4_4_t                r_mem [N_NEURONS];
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;

    logic [N_NEURONS-1:0] w_event;
    lif_result_t          w_step;
    logic                 w_push;
    logic                 w_fifo_empty;
    logic                 w_start;

    assign w_event  = bus.in_valid ? ({{(N_NEURONS-1){1'b0}}, 1'b1} << bus.in_idx) : '0;
    assign w_step   = lif_step(r_mem[r_cnt], r_snapshot[r_cnt], LAMBDA, THRESHOLD,
                               SPIKE_WEIGHT, RESET_LEVEL);
    assign w_push   = (r_state == UPDATE) && w_step.fire;
    assign w_start  = (r_state == IDLE) && tick;

    assign bus.in_ready = rst_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign tick_overrun = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_snapshot <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++)
                r_mem[i] <= RESET_LEVEL;
        end else begin
            r_done <= 1'b0;
            if (tick && (r_state != IDLE))
                r_overrun <= 1'b1;
            // A same-cycle event joins the snapshot, so pending restarts empty
            if (w_start)
                r_pending <= '0;
            else
                r_pending <= r_pending | w_event;

            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_snapshot <= r_pending | w_event;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_mem[r_cnt] <= w_step.p;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == IDX_W'(N_NEURONS - 1))
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_fifo_empty) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    spike_fifo #(
        .DEPTH (N_NEURONS),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_idx  (r_cnt),
        .pop       (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_idx   (bus.out_idx),
        .empty     (w_fifo_empty)
    );
endmodule
`default_nettype wire

// File: doc/lif_layer_scheduler.md
# lif_layer_scheduler

Time-multiplexed controller that shares one Q4.4 leaky-integrate-and-fire update datapath across `N_NEURONS` virtual neurons. It collects input spike events between timesteps and sweeps every neuron once per `tick`, one neuron per cycle. Membrane state lives in a local register array, and output spikes leave through a valid/ready event stream. It sits between the spike-routing fabric and the next layer, replacing per-neuron instances of the LIF cell.

## Interface
- `N_NEURONS`, 16: number of virtual neurons; power of two, 2..256.
- `IDX_W`, $clog2(N_NEURONS): neuron index width.
- `LAMBDA`, 8'sb0001_0100: leak multiplier, Q4.4 (1.25).
- `THRESHOLD`, 8'sb0100_0000: fire threshold, Q4.4 (4.0).
- `RESET_LEVEL`, 8'sb0000_0000: post-fire and reset membrane value, Q4.4.
- `SPIKE_WEIGHT`, 8'sb0001_0000: increment for an input spike, Q4.4 (1.0).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tick`, input, 1: single-cycle pulse that starts a timestep.
- `in_valid`, input, 1: input spike event valid.
- `in_ready`, output, 1: always 1 outside reset; events are never back-pressured.
- `in_idx`, input, IDX_W: target neuron of the input event.
- `out_valid`, output, 1: output spike event valid.
- `out_ready`, input, 1: downstream accepts the output event.
- `out_idx`, output, IDX_W: neuron that fired.
- `busy`, output, 1: high in UPDATE or DRAIN.
- `done`, output, 1: one-cycle pulse when the timestep completes.
- `tick_overrun`, output, 1: sticky flag; set when `tick` arrives while busy. Cleared only by reset.

## Operation
- Pending bitmap (N bits) latches input events: `in_valid` sets `pending[in_idx]`.
  - Duplicate events within one step collapse to a single spike.
- FSM states: IDLE, UPDATE, DRAIN.
  - **IDLE:** on `tick`, copy `snapshot = pending | (in_valid ? onehot(in_idx) : 0)`, clear `pending`, reset the sweep counter to 0, go to UPDATE.
  - **UPDATE:** process neuron `k` = counter value, then increment. After `k = N_NEURONS-1`, go to DRAIN.
  - **DRAIN:** wait until the output FIFO is empty. Then pulse `done` and return to IDLE.
- Events arriving during UPDATE or DRAIN go to `pending` for the next timestep. They never affect the current snapshot.
- Per-neuron update for neuron k:
  - `mul = P[k] * LAMBDA`, signed 16-bit; `leak = mul[11:4]`.
  - `sum = leak + (snapshot[k] ? SPIKE_WEIGHT : 0)`, computed as signed 9-bit, then saturated to [-128, 127].
  - If `sum >= THRESHOLD`: write `P[k] = RESET_LEVEL` and push `k` to the output FIFO. Otherwise write `P[k] = sum`.
- The output FIFO depth is `N_NEURONS`. It is empty at every sweep start, so it cannot overflow, and UPDATE never stalls.
- `tick` while busy is ignored (the step is not queued) and sets `tick_overrun`.
- Reset, including mid-sweep, is asynchronous:
  - all `P` cleared to RESET_LEVEL;
  - `pending`, `snapshot` and FIFO cleared;
  - state returns to IDLE;
  - the in-flight step is abandoned with no `done`.

## Timing
- Reset values: `in_ready`=0 during reset and 1 otherwise; `out_valid`=0, `out_idx`=0, `busy`=0, `done`=0, `tick_overrun`=0.
- `tick` sampled at edge t. Neuron k is updated at edge t+1+k, and its output event becomes visible (`out_valid`) after edge t+2+k at the earliest.
- `busy` is high from cycle t+1 through the DRAIN exit.
  - With `out_ready` held high, `done` asserts N_NEURONS+2 cycles after `tick`.
- Output handshake:
  - A transfer occurs on a cycle where `out_valid && out_ready`.
  - `out_idx` is stable while `out_valid && !out_ready`.
  - Events emerge in ascending index order within a step.
- Membrane reads in UPDATE are combinational from the array; the write happens at the same edge.

## Structure
- Package `lif_pkg` holds:
  - `q4_4_t` (`logic signed [7:0]`);
  - the state enum `sched_state_e` {IDLE, UPDATE, DRAIN};
  - function `lif_step(q4_4_t p, logic spike)`, which returns the new potential and a fire bit, used by both RTL and the bench model.
- Sub-module `spike_fifo`: synchronous FIFO with parameters depth and width, registered `out_valid`/`out_idx`, and an empty flag.

## Test plan
- **Single neuron driven each step:** neuron 3 receives one event before each of 4 ticks.
  - P[3] = 1.0, 2.25, 3.8125, then fires on step 4 (sum 5.75 ≥ 4.0).
  - `out_idx`=3 appears once; P[3]=0.
- **Full fire:** preload so that all 16 neurons cross threshold in one step, and hold `out_ready`=0 for 20 cycles.
  - All 16 events are buffered, then emerge as 0..15 in order; `done` follows the last transfer.
- **Event during sweep:** `in_idx`=5 arrives mid-UPDATE.
  - It is absent from this step's snapshot (P[5] unchanged from 0) and applied on the next tick.
- **Tick while busy:** second `tick` during UPDATE.
  - Ignored, `tick_overrun`=1, sweep count unchanged; `done` pulses once.
- **Simultaneous event and tick in IDLE:** `in_idx`=7 is included in the current step, with P[7]=1.0 after the sweep.
- **Reset mid-UPDATE at k=8:** all outputs return to reset values, the FIFO is empty, no `done`; the next tick gives all P = 0 with no events.
